// File: rtl/instr_encoder_loader_pkg.sv
// instr_encoder_loader_pkg: opcode enum, prefixes and status codes shared by encoder, loader and decoder
package instr_encoder_loader_pkg;
  typedef enum logic [3:0] {
    OP_ADDI, OP_SUBI, OP_SR0, OP_SRH0, OP_CLR, OP_MOV,
    OP_BR, OP_BRZ, OP_MOVA, OP_MOVR, OP_MOVRHS, OP_PAUSE
  } op_e;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_DONE, S_ERROR} state_e;
  localparam logic [2:0] PFX_ADDI = 3'b000, PFX_SUBI = 3'b001, PFX_BR = 3'b100, PFX_BRZ = 3'b101;
  localparam logic [3:0] PFX_SR0 = 4'b0100, PFX_SRH0 = 4'b0101, PFX_MOV = 4'b0111;
  localparam logic [5:0] PFX_CLR = 6'b011000, PFX_MOVA = 6'b110000, PFX_MOVR = 6'b110001;
  localparam logic [5:0] PFX_MOVRHS = 6'b110010, PFX_PAUSE = 6'b111111;
  localparam logic [7:0] PAUSE_WORD = 8'hFC;
  localparam logic [1:0] ERR_NONE = 2'd0, ERR_RANGE = 2'd1, ERR_OPCODE = 2'd2, ERR_OVERFLOW = 2'd3;
endpackage

// File: rtl/instr_encode.sv
// instr_encode: packs one symbolic command into the 8-bit instruction word and flags illegal input
module instr_encode
  import instr_encoder_loader_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic [3:0] op,
  input  logic [4:0] arg,
  output logic [7:0] word,
  output logic       range_err,
  output logic       op_err
);
  always_comb begin
    word = '0;
    range_err = 1'b0;
    op_err = 1'b0;
    case (op)
      OP_ADDI:   word = {PFX_ADDI, arg};
      OP_SUBI:   word = {PFX_SUBI, arg};
      OP_SR0:    begin word = {PFX_SR0, arg[3:0]}; range_err = arg[4]; end
      OP_SRH0:   begin word = {PFX_SRH0, arg[3:0]}; range_err = arg[4]; end
      OP_CLR:    begin word = {PFX_CLR, arg[1:0]}; range_err = |arg[4:2]; end
      OP_MOV:    begin word = {PFX_MOV, arg[3:0]}; range_err = arg[4]; end
      OP_BR:     begin word = {PFX_BR, arg}; range_err = {1'b0, arg} >= 6'(DEPTH); end
      OP_BRZ:    begin word = {PFX_BRZ, arg}; range_err = {1'b0, arg} >= 6'(DEPTH); end
      OP_MOVA:   begin word = {PFX_MOVA, arg[1:0]}; range_err = |arg[4:2]; end
      OP_MOVR:   begin word = {PFX_MOVR, arg[1:0]}; range_err = |arg[4:2]; end
      OP_MOVRHS: begin word = {PFX_MOVRHS, arg[1:0]}; range_err = |arg[4:2]; end
      OP_PAUSE:  begin word = {PFX_PAUSE, arg[1:0]}; range_err = |arg[4:2]; end
      default:   op_err = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: streams encoded commands into program memory and reports session status.
// Define PAD_PAUSE_EN to pad the unused tail of memory with PAUSE words after the last command.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [4:0]        cmd_arg,
  input  logic              cmd_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  state_e state, nxt;
  logic [ADDR_W:0] count_n;
  logic [1:0] code_n;
  logic we_n, range_err, op_err;
  logic [7:0] word, wdata_n;
  instr_encode #(.DEPTH(DEPTH)) u_enc (
    .op(cmd_op), .arg(cmd_arg), .word(word), .range_err(range_err), .op_err(op_err)
  );
  assign cmd_ready = state == S_LOAD;
  assign busy = state == S_LOAD || state == S_FILL;
  assign done = state == S_DONE;
  assign err = state == S_ERROR;
  always_comb begin
    nxt = state;
    count_n = count;
    code_n = err_code;
    we_n = 1'b0;
    wdata_n = word;
    case (state)
      S_LOAD: if (cmd_valid) begin
        if (count == FULL) begin
          nxt = S_ERROR;
          code_n = ERR_OVERFLOW;
        end else if (op_err || range_err) begin
          nxt = S_ERROR;
          code_n = op_err ? ERR_OPCODE : ERR_RANGE;
        end else begin
          we_n = 1'b1;
          count_n = count + 1'b1;
`ifdef PAD_PAUSE_EN
          if (cmd_last) nxt = (count == FULL - 1'b1) ? S_DONE : S_FILL;
`else
          if (cmd_last) nxt = S_DONE;
`endif
        end
      end
`ifdef PAD_PAUSE_EN
      // one PAUSE per cycle; DONE follows the cycle after the last pad word
      S_FILL: if (count == FULL) nxt = S_DONE;
      else begin
        we_n = 1'b1;
        wdata_n = PAUSE_WORD;
        count_n = count + 1'b1;
      end
`endif
      default: if (start) begin
        nxt = S_LOAD;
        count_n = '0;
        code_n = ERR_NONE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      count <= '0;
      err_code <= ERR_NONE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nxt;
      count <= count_n;
      err_code <= code_n;
      mem_we <= we_n;
      if (we_n) begin
        mem_addr <= count[ADDR_W-1:0];
        mem_wdata <= wdata_n;
      end
    end
  end
endmodule
